// File: rtl/mapping_table_report_sequencer_pkg.sv
// Shared constants, table selects and FSM encoding for the mapping-table report sequencer.
package mapping_table_report_sequencer_pkg;

  localparam int DEF_RD_LATENCY = 3;
  localparam int DEF_MAX_RETRY  = 15;

  localparam int TUPLE_DEPTH   = 32;
  localparam int REGROUP_DEPTH = 256;
  localparam int TUPLE_AW      = 5;
  localparam int REGROUP_AW    = 8;
  localparam int IDX_W         = 8;
  localparam int RETRY_W       = 4;
  localparam int WAIT_W        = 4;

  localparam logic [IDX_W-1:0] TUPLE_LAST   = IDX_W'(TUPLE_DEPTH - 1);
  localparam logic [IDX_W-1:0] REGROUP_LAST = IDX_W'(REGROUP_DEPTH - 1);

  localparam int TUPLE_DW   = 152;
  localparam int REGROUP_DW = 57;
  localparam int REPORT_DW  = TUPLE_DW;

  localparam logic TBL_5TUPLE  = 1'b0;
  localparam logic TBL_REGROUP = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_OUTPUT = 3'd4
  } state_t;

  function automatic logic [IDX_W-1:0] last_index(input logic tbl);
    return (tbl == TBL_REGROUP) ? REGROUP_LAST : TUPLE_LAST;
  endfunction

endpackage

// File: rtl/mapping_table_report_sequencer_report_entry_holder.sv
// Output register slice for one report entry; valid drops only on a handshake.
module report_entry_holder
  import mapping_table_report_sequencer_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [REPORT_DW-1:0] iv_data,
  input  logic [IDX_W-1:0]     iv_index,
  input  logic                 i_table,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [REPORT_DW-1:0] ov_data,
  output logic [IDX_W-1:0]     ov_index,
  output logic                 o_table
);

  logic                 valid_q, valid_d;
  logic [REPORT_DW-1:0] data_q, data_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic                 table_q, table_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    table_d = table_q;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = iv_data;
      index_d = iv_index;
      table_d = i_table;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      table_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      table_q <= table_d;
    end
  end

  assign o_valid  = valid_q;
  assign ov_data  = data_q;
  assign ov_index = index_q;
  assign o_table  = table_q;

endmodule

// File: rtl/mapping_table_report_sequencer.sv
// Walks the 5-tuple or regroup mapping table through the RAM arbiter read port,
// retrying conflicted reads, and streams each entry out over valid/ready.
module mapping_table_report_sequencer
  import mapping_table_report_sequencer_pkg::*;
#(
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_report_req,
  input  logic                  i_report_table,
  output logic [TUPLE_AW-1:0]   ov_5tuple_ram_raddr,
  output logic                  o_5tuple_ram_rd,
  input  logic [TUPLE_DW-1:0]   iv_5tuple_ram_rdata,
  input  logic                  i_5tupleram_read_write_conflict,
  output logic [REGROUP_AW-1:0] ov_regroup_ram_raddr,
  output logic                  o_regroup_ram_rd,
  input  logic [REGROUP_DW-1:0] iv_regroup_ram_rdata,
  input  logic                  i_regroupram_read_write_conflict,
  output logic [REPORT_DW-1:0]  ov_report_data,
  output logic [IDX_W-1:0]      ov_report_index,
  output logic                  o_report_table,
  output logic                  o_report_valid,
  input  logic                  i_report_ready,
  output logic                  o_report_busy,
  output logic                  o_report_done,
  output logic                  o_report_err
);

  state_t               state_q, state_d;
  logic                 tbl_q, tbl_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 err_q, err_d;

  logic                 conflict;
  logic                 retry_exhausted;
  logic                 is_last;
  logic                 handshake;
  logic                 load;
  logic [REPORT_DW-1:0] load_data;
  logic [WAIT_W-1:0]    wait_dec;

  assign conflict        = (tbl_q == TBL_REGROUP) ? i_regroupram_read_write_conflict
                                                  : i_5tupleram_read_write_conflict;
  assign retry_exhausted = (retry_q == RETRY_W'(MAX_RETRY));
  assign is_last         = (index_q == last_index(tbl_q));
  assign handshake       = o_report_valid && i_report_ready;
  assign wait_dec        = wait_q - WAIT_W'(1);
  assign load_data       = (tbl_q == TBL_REGROUP)
                           ? {{(REPORT_DW-REGROUP_DW){1'b0}}, iv_regroup_ram_rdata}
                           : iv_5tuple_ram_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      tbl_q   <= TBL_5TUPLE;
      index_q <= '0;
      retry_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      index_q <= index_d;
      retry_q <= retry_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_report_req) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_WAIT;
      ST_WAIT:   if (wait_dec == '0) state_d = ST_CHECK;
      ST_CHECK: begin
        if (!conflict)            state_d = ST_OUTPUT;
        else if (retry_exhausted) state_d = ST_IDLE;
        else                      state_d = ST_ISSUE;
      end
      ST_OUTPUT: if (handshake) state_d = is_last ? ST_IDLE : ST_ISSUE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Counters and sticky flags; a retry keeps the index so the same entry is re-read.
  always_comb begin
    tbl_d   = tbl_q;
    index_d = index_q;
    retry_d = retry_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_report_req) begin
          tbl_d   = i_report_table;
          index_d = '0;
          retry_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_ISSUE: wait_d = WAIT_W'(RD_LATENCY - 1);
      ST_WAIT:  wait_d = wait_dec;
      ST_CHECK: begin
        if (!conflict)            retry_d = '0;
        else if (retry_exhausted) err_d   = 1'b1;
        else                      retry_d = retry_q + RETRY_W'(1);
      end
      ST_OUTPUT: if (handshake && !is_last) index_d = index_q + IDX_W'(1);
      default: ;
    endcase
  end

  always_comb begin
    o_5tuple_ram_rd      = (state_q == ST_ISSUE) && (tbl_q == TBL_5TUPLE);
    o_regroup_ram_rd     = (state_q == ST_ISSUE) && (tbl_q == TBL_REGROUP);
    ov_5tuple_ram_raddr  = o_5tuple_ram_rd  ? index_q[TUPLE_AW-1:0]   : '0;
    ov_regroup_ram_raddr = o_regroup_ram_rd ? index_q[REGROUP_AW-1:0] : '0;
    load                 = (state_q == ST_CHECK) && !conflict;
    o_report_done        = ((state_q == ST_CHECK) && conflict && retry_exhausted) ||
                           ((state_q == ST_OUTPUT) && handshake && is_last);
    o_report_busy        = (state_q != ST_IDLE);
    o_report_err         = err_q;
  end

  report_entry_holder u_holder (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (load),
    .iv_data  (load_data),
    .iv_index (index_q),
    .i_table  (tbl_q),
    .i_ready  (i_report_ready),
    .o_valid  (o_report_valid),
    .ov_data  (ov_report_data),
    .ov_index (ov_report_index),
    .o_table  (o_report_table)
  );

endmodule

// File: tb/tb_mapping_table_report_sequencer.sv
// Scoreboard bench: expected entries queued at start, monitor pops on each handshake.
module tb_mapping_table_report_sequencer;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_report_req;
  logic         i_report_table;
  logic [4:0]   ov_5tuple_ram_raddr;
  logic         o_5tuple_ram_rd;
  logic [151:0] iv_5tuple_ram_rdata;
  logic         i_5tupleram_read_write_conflict;
  logic [7:0]   ov_regroup_ram_raddr;
  logic         o_regroup_ram_rd;
  logic [56:0]  iv_regroup_ram_rdata;
  logic         i_regroupram_read_write_conflict;
  logic [151:0] ov_report_data;
  logic [7:0]   ov_report_index;
  logic         o_report_table;
  logic         o_report_valid;
  logic         i_report_ready;
  logic         o_report_busy;
  logic         o_report_done;
  logic         o_report_err;

  always #5 i_clk = ~i_clk;

  mapping_table_report_sequencer dut (
    .i_clk                            (i_clk),
    .i_rst_n                          (i_rst_n),
    .i_report_req                     (i_report_req),
    .i_report_table                   (i_report_table),
    .ov_5tuple_ram_raddr              (ov_5tuple_ram_raddr),
    .o_5tuple_ram_rd                  (o_5tuple_ram_rd),
    .iv_5tuple_ram_rdata              (iv_5tuple_ram_rdata),
    .i_5tupleram_read_write_conflict  (i_5tupleram_read_write_conflict),
    .ov_regroup_ram_raddr             (ov_regroup_ram_raddr),
    .o_regroup_ram_rd                 (o_regroup_ram_rd),
    .iv_regroup_ram_rdata             (iv_regroup_ram_rdata),
    .i_regroupram_read_write_conflict (i_regroupram_read_write_conflict),
    .ov_report_data                   (ov_report_data),
    .ov_report_index                  (ov_report_index),
    .o_report_table                   (o_report_table),
    .o_report_valid                   (o_report_valid),
    .i_report_ready                   (i_report_ready),
    .o_report_busy                    (o_report_busy),
    .o_report_done                    (o_report_done),
    .o_report_err                     (o_report_err)
  );

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // RAM/arbiter model: data and conflict appear 3 cycles after the strobe cycle.
  typedef struct packed {
    logic       vld;
    logic       tbl;
    logic [7:0] addr;
    logic       conf;
  } rd_stage_t;

  rd_stage_t  st1 = '0, st2 = '0, st3 = '0;
  int         conf_mode = 0;
  logic [7:0] conf_addr = '0;
  int         log_base = 0;
  int         strobe_cyc[$];
  logic [7:0] strobe_addr[$];

  function automatic logic [56:0] rg_data(input logic [7:0] a);
    return {1'b1, 48'hC0FFEE000000, a};
  endfunction

  always @(posedge i_clk) begin
    rd_stage_t n;
    bit        seen;
    n = '0;
    if (o_5tuple_ram_rd) begin
      n.vld = 1'b1; n.tbl = 1'b0; n.addr = {3'b000, ov_5tuple_ram_raddr};
    end else if (o_regroup_ram_rd) begin
      n.vld = 1'b1; n.tbl = 1'b1; n.addr = ov_regroup_ram_raddr;
    end
    if (n.vld) begin
      seen = 1'b0;
      for (int i = log_base; i < strobe_addr.size(); i++)
        if (strobe_addr[i] == conf_addr) seen = 1'b1;
      if (conf_mode == 2 && n.addr == conf_addr) n.conf = 1'b1;
      if (conf_mode == 1 && n.addr == conf_addr && !seen) n.conf = 1'b1;
      strobe_cyc.push_back(cyc);
      strobe_addr.push_back(n.addr);
    end
    st1 <= n;
    st2 <= st1;
    st3 <= st2;
  end

  assign iv_5tuple_ram_rdata  = (st3.vld && !st3.tbl) ? {147'b0, st3.addr[4:0]} : '0;
  assign iv_regroup_ram_rdata = (st3.vld &&  st3.tbl) ? rg_data(st3.addr) : '0;
  assign i_5tupleram_read_write_conflict  = st3.vld && !st3.tbl && st3.conf;
  assign i_regroupram_read_write_conflict = st3.vld &&  st3.tbl && st3.conf;

  int ready_mode = 0;
  initial begin
    i_report_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      i_report_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  // Scoreboard and posted checks; only the monitor touches the counters.
  typedef struct packed {
    logic [151:0] data;
    logic [7:0]   idx;
    logic         tbl;
  } ent_t;

  typedef struct {
    string        name;
    logic [151:0] act;
    logic [151:0] exp;
  } chk_t;

  ent_t exp_q[$];
  chk_t chk_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  logic cur_tbl = 1'b0;
  bit   hold_pending = 1'b0;
  ent_t held;

  task automatic do_chk(input string nm, input logic [151:0] a, input logic [151:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  always @(negedge i_clk) begin
    ent_t cur, e;
    chk_t c;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      do_chk(c.name, c.act, c.exp);
    end
    if (i_rst_n) begin
      cur = '{ov_report_data, ov_report_index, o_report_table};
      if (hold_pending)
        do_chk("hold_stable", {o_report_valid, cur}, {1'b1, held});
      if (o_report_valid && i_report_ready) begin
        if (exp_q.size() == 0) begin
          do_chk("unexpected_entry", {143'b0, 1'b1, ov_report_index}, 152'b0);
        end else begin
          e = exp_q.pop_front();
          do_chk("entry", cur, e);
        end
      end
      hold_pending = o_report_valid && !i_report_ready;
      held = cur;
      do_chk("strobe_rules",
             {148'b0,
              o_5tuple_ram_rd && o_regroup_ram_rd,
              !o_5tuple_ram_rd && ov_5tuple_ram_raddr != 5'd0,
              !o_regroup_ram_rd && ov_regroup_ram_raddr != 8'd0,
              (cur_tbl ? o_5tuple_ram_rd : o_regroup_ram_rd)},
             152'b0);
      if (o_report_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic post(input string nm, input logic [151:0] a, input logic [151:0] e);
    chk_t c;
    c.name = nm; c.act = a; c.exp = e;
    chk_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_walk(input logic tbl, input int n);
    for (int i = 0; i < n; i++) begin
      if (tbl) exp_q.push_back('{{95'b0, rg_data(8'(i))}, 8'(i), 1'b1});
      else     exp_q.push_back('{{147'b0, 5'(i)}, 8'(i), 1'b0});
    end
  endtask

  task automatic start(input logic tbl, output int t);
    log_base = strobe_addr.size();
    cur_tbl = tbl;
    i_report_table = tbl;
    i_report_req = 1'b1;
    t = cyc;
    tick();
    i_report_req = 1'b0;
    i_report_table = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) post(nm, 152'd0, 152'd1);
  endtask

  function automatic int count_addr(input logic [7:0] a);
    int k = 0;
    for (int i = log_base; i < strobe_addr.size(); i++)
      if (strobe_addr[i] == a) k++;
    return k;
  endfunction

  function automatic int gap_addr(input logic [7:0] a);
    int first = -1;
    for (int i = log_base; i < strobe_addr.size(); i++) begin
      if (strobe_addr[i] == a) begin
        if (first < 0) first = strobe_cyc[i];
        else return strobe_cyc[i] - first;
      end
    end
    return -1;
  endfunction

  initial begin
    int t, d0;
    i_rst_n = 1'b0;
    i_report_req = 1'b0;
    i_report_table = 1'b0;
    repeat (3) tick();
    post("reset_ctrl", {124'b0, o_5tuple_ram_rd, o_regroup_ram_rd, ov_5tuple_ram_raddr,
                        ov_regroup_ram_raddr, o_report_valid, o_report_busy, o_report_done,
                        o_report_err, o_report_table, ov_report_index}, 152'b0);
    post("reset_data", ov_report_data, 152'b0);
    i_rst_n = 1'b1;
    tick();

    // Full 5-tuple walk, ready always high.
    push_walk(1'b0, 32);
    start(1'b0, t);
    post("t1_busy", 152'(o_report_busy), 152'd1);
    post("t1_first_rd", {o_5tuple_ram_rd, ov_5tuple_ram_raddr}, {1'b1, 5'd0});
    wait_done(400, "t1_done_timeout");
    post("t1_done_cycle", 152'(done_cyc - t), 152'd160);
    post("t1_err", 152'(o_report_err), 152'd0);
    post("t1_strobes", 152'(strobe_addr.size() - log_base), 152'd32);
    tick();
    post("t1_idle", 152'(o_report_busy), 152'd0);
    post("t1_sb_empty", 152'(exp_q.size()), 152'd0);

    // Regroup walk with ready high one cycle in three.
    ready_mode = 1;
    push_walk(1'b1, 256);
    start(1'b1, t);
    post("t2_first_rd", {o_regroup_ram_rd, ov_regroup_ram_raddr}, {1'b1, 8'd0});
    wait_done(4000, "t2_done_timeout");
    post("t2_strobes", 152'(strobe_addr.size() - log_base), 152'd256);
    post("t2_err", 152'(o_report_err), 152'd0);
    post("t2_sb_empty", 152'(exp_q.size()), 152'd0);
    ready_mode = 0;
    repeat (2) tick();

    // One conflict on the first read of index 5.
    conf_mode = 1;
    conf_addr = 8'd5;
    push_walk(1'b0, 32);
    start(1'b0, t);
    wait_done(500, "t3_done_timeout");
    post("t3_reads_at_5", 152'(count_addr(8'd5)), 152'd2);
    post("t3_retry_gap", 152'(gap_addr(8'd5)), 152'd4);
    post("t3_done_cycle", 152'(done_cyc - t), 152'd164);
    post("t3_sb_empty", 152'(exp_q.size()), 152'd0);
    conf_mode = 0;
    tick();

    // Permanent conflict at index 7: abort after 16 reads.
    conf_mode = 2;
    conf_addr = 8'd7;
    push_walk(1'b0, 7);
    start(1'b0, t);
    wait_done(300, "t4_done_timeout");
    post("t4_reads_at_7", 152'(count_addr(8'd7)), 152'd16);
    post("t4_done_cycle", 152'(done_cyc - t), 152'd99);
    post("t4_err", 152'(o_report_err), 152'd1);
    post("t4_sb_empty", 152'(exp_q.size()), 152'd0);
    tick();
    post("t4_idle_err", {o_report_busy, o_report_err}, {1'b0, 1'b1});
    conf_mode = 0;
    tick();

    // New start clears err; a mid-walk request is ignored.
    push_walk(1'b0, 32);
    start(1'b0, t);
    post("t5_err_cleared", {o_report_busy, o_report_err}, {1'b1, 1'b0});
    repeat (50) tick();
    i_report_table = 1'b1;
    i_report_req = 1'b1;
    tick();
    i_report_req = 1'b0;
    i_report_table = 1'b0;
    wait_done(400, "t5_done_timeout");
    post("t5_done_cycle", 152'(done_cyc - t), 152'd160);
    post("t5_strobes", 152'(strobe_addr.size() - log_base), 152'd32);
    post("t5_sb_empty", 152'(exp_q.size()), 152'd0);
    tick();

    // Reset while waiting on the read of index 3.
    push_walk(1'b0, 3);
    start(1'b0, t);
    repeat (16) tick();
    post("t6_last_rd", {24'(cyc - strobe_cyc[$]), strobe_addr[$]}, {24'd1, 8'd3});
    d0 = done_cnt;
    i_rst_n = 1'b0;
    #1;
    post("t6_rst_ctrl", {124'b0, o_5tuple_ram_rd, o_regroup_ram_rd, ov_5tuple_ram_raddr,
                         ov_regroup_ram_raddr, o_report_valid, o_report_busy, o_report_done,
                         o_report_err, o_report_table, ov_report_index}, 152'b0);
    post("t6_rst_data", ov_report_data, 152'b0);
    post("t6_sb_empty", 152'(exp_q.size()), 152'd0);
    repeat (2) tick();
    post("t6_no_done", 152'(done_cnt - d0), 152'd0);
    i_rst_n = 1'b1;
    tick();
    push_walk(1'b0, 32);
    start(1'b0, t);
    post("t6_restart_rd", {o_report_busy, o_5tuple_ram_rd, ov_5tuple_ram_raddr}, {2'b11, 5'd0});
    wait_done(400, "t6_done_timeout");
    post("t6_done_cycle", 152'(done_cyc - t), 152'd160);
    post("t6_done_count", 152'(done_cnt - d0), 152'd1);
    post("t6_sb_empty", 152'(exp_q.size()), 152'd0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
